// File: rtl/trng_buf_stream.sv
// TRNG word assembler with a show-ahead FIFO and a button-triggered burst streamer.
// Optional repetition-count health test is enabled with `define TRNG_HEALTH_EN.
module trng_buf_stream #(
   parameter int WORD_W     = 32,
   parameter int DEPTH      = 16,
   parameter int BURST_LEN  = 8,
   parameter int RCT_CUTOFF = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rnd_bit,
   input  logic                     rnd_valid,
   input  logic                     button,
   output logic [WORD_W-1:0]        data_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     loading_out,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              drop_cnt,
   output logic                     health_fail
);

   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;
   localparam int BCW = $clog2(WORD_W) + 1;
   localparam logic [LW-1:0]  DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0]  ONE_L    = LW'(1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(WORD_W - 1);
   localparam logic [15:0]    BURST_L  = 16'(BURST_LEN);

   if (WORD_W < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       BURST_LEN < 1 || BURST_LEN > 65535 || RCT_CUTOFF < 2) begin : g_bad_param
      $error("trng_buf_stream: illegal parameter combination");
   end

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

   logic [WORD_W-2:0] acc_r;
   logic [BCW-1:0]    bit_cnt_r;
   logic [WORD_W-1:0] word_s;
   logic [WORD_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]     level_r, level_nxt_s;
   logic              full_r, empty_r;
   logic [15:0]       drop_cnt_r;
   logic              btn_meta_r, btn_sync_r, btn_prev_r, req_s;
   state_t            state_r, state_nxt_s;
   logic [15:0]       burst_cnt_r, burst_nxt_s;
   logic              word_done_s, push_ok_s, drop_s, pop_s, out_valid_s;
   logic              inhibit_s, discard_s;

`ifdef TRNG_HEALTH_EN
   localparam int RW = $clog2(RCT_CUTOFF) + 1;
   localparam logic [RW-1:0] RCT_L = RW'(RCT_CUTOFF);

   logic [RW-1:0] rct_cnt_r, rct_cnt_nxt_s;
   logic          rct_last_r, health_fail_r, rct_trip_s;

   // Run length of the current bit value; a fresh run starts at 1.
   always_comb begin
      rct_cnt_nxt_s = RW'(1);
      if (rct_cnt_r != {RW{1'b0}} && rnd_bit == rct_last_r) begin
         rct_cnt_nxt_s = rct_cnt_r + RW'(1);
      end else begin
         rct_cnt_nxt_s = RW'(1);
      end
      rct_trip_s = rnd_valid && !health_fail_r && (rct_cnt_nxt_s == RCT_L);
   end

   // Repetition-count state; the alarm latches until reset and freezes the counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rct_cnt_r     <= {RW{1'b0}};
         rct_last_r    <= 1'b0;
         health_fail_r <= 1'b0;
      end else if (rnd_valid && !health_fail_r) begin
         rct_cnt_r  <= rct_cnt_nxt_s;
         rct_last_r <= rnd_bit;
         if (rct_trip_s) begin
            health_fail_r <= 1'b1;
         end
      end
   end

   assign health_fail = health_fail_r;
   assign inhibit_s   = health_fail_r | rct_trip_s;
   assign discard_s   = rct_trip_s;
`else
   assign health_fail = 1'b0;
   assign inhibit_s   = 1'b0;
   assign discard_s   = 1'b0;
`endif

   // First bit received lands in the MSB once WORD_W bits have been shifted in.
   assign word_s      = {acc_r, rnd_bit};
   assign word_done_s = rnd_valid && (bit_cnt_r == BIT_LAST) && !inhibit_s;
   assign out_valid_s = (state_r == ST_SEND) && !empty_r;
   assign pop_s       = out_valid_s && out_ready;
   assign push_ok_s   = word_done_s && (!full_r || pop_s);
   assign drop_s      = word_done_s && full_r && !pop_s;

   // Serial word accumulator and bit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r     <= {(WORD_W-1){1'b0}};
         bit_cnt_r <= {BCW{1'b0}};
      end else if (discard_s) begin
         acc_r     <= {(WORD_W-1){1'b0}};
         bit_cnt_r <= {BCW{1'b0}};
      end else if (rnd_valid) begin
         acc_r     <= word_s[WORD_W-2:0];
         bit_cnt_r <= (bit_cnt_r == BIT_LAST) ? {BCW{1'b0}} : bit_cnt_r + BCW'(1);
      end
   end

   // Occupancy after this cycle's push/pop.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_ok_s, pop_s})
         2'b10:   level_nxt_s = level_r + ONE_L;
         2'b01:   level_nxt_s = level_r - ONE_L;
         default: level_nxt_s = level_r;
      endcase
   end

   // FIFO storage; no reset needed since data_out is masked while empty.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= word_s;
      end
   end

   // FIFO pointers, registered status flags and saturating drop counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= {LW{1'b0}};
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         drop_cnt_r <= 16'd0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         level_r <= level_nxt_s;
         full_r  <= (level_nxt_s == DEPTH_L);
         empty_r <= (level_nxt_s == {LW{1'b0}});
         if (drop_s && drop_cnt_r != 16'hFFFF) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
         end
      end
   end

   // Button synchroniser plus edge-detect history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_meta_r <= 1'b0;
         btn_sync_r <= 1'b0;
         btn_prev_r <= 1'b0;
      end else begin
         btn_meta_r <= button;
         btn_sync_r <= btn_meta_r;
         btn_prev_r <= btn_sync_r;
      end
   end

   assign req_s = btn_sync_r && !btn_prev_r;

   // Burst FSM next state; presses during SEND are deliberately dropped.
   always_comb begin
      state_nxt_s = state_r;
      burst_nxt_s = burst_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               state_nxt_s = ST_SEND;
               burst_nxt_s = BURST_L;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (pop_s) begin
               burst_nxt_s = burst_cnt_r - 16'd1;
               state_nxt_s = (burst_cnt_r == 16'd1) ? ST_IDLE : ST_SEND;
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            burst_nxt_s = 16'd0;
         end
      endcase
   end

   // Burst FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         burst_cnt_r <= 16'd0;
      end else begin
         state_r     <= state_nxt_s;
         burst_cnt_r <= burst_nxt_s;
      end
   end

   assign data_out    = empty_r ? {WORD_W{1'b0}} : mem_r[rd_ptr_r];
   assign out_valid   = out_valid_s;
   assign loading_out = (state_r == ST_SEND);
   assign full        = full_r;
   assign empty       = empty_r;
   assign level       = level_r;
   assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_trng_buf_stream.sv
// Directed self-checking bench for trng_buf_stream with default parameters.
module tb_trng_buf_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rnd_bit = 1'b0;
   logic        rnd_valid = 1'b0;
   logic        button = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] data_out;
   logic        out_valid, loading_out, full, empty, health_fail;
   logic [4:0]  level;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];

   trng_buf_stream dut (
      .clk(clk), .rst(rst), .rnd_bit(rnd_bit), .rnd_valid(rnd_valid), .button(button),
      .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
      .loading_out(loading_out), .full(full), .empty(empty), .level(level),
      .drop_cnt(drop_cnt), .health_fail(health_fail)
   );

   always #5 clk = ~clk;

   // Record every completed handshake, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) got_q.push_back(data_out);
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; rnd_valid = 1'b0; rnd_bit = 1'b0; button = 1'b0; out_ready = 1'b0;
      step(2);
      rst = 1'b1;
      step(1);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic feed_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) begin
         rnd_bit = w[i]; rnd_valid = 1'b1;
         step(1);
      end
      rnd_valid = 1'b0; rnd_bit = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (loading_out && n < max) begin
         step(1);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(2);
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
      total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
      total++; if ({out_valid, loading_out, full, health_fail} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags: got %b want 0000", {out_valid, loading_out, full, health_fail}); end
      total++; if ({data_out, drop_cnt} !== 48'd0) begin
         bad++; $display("FAIL reset_data: got %h/%h want 0/0", data_out, drop_cnt); end
   endtask

   task automatic test_assembly();
      rst = 1'b1;
      step(1);
      feed_word(32'hA5A5_0F0F);
      total++; if (level !== 5'd1) begin bad++; $display("FAIL asm_level: got %0d want 1", level); end
      total++; if (data_out !== 32'hA5A5_0F0F) begin bad++; $display("FAIL asm_data: got %h want a5a50f0f", data_out); end
      total++; if (empty !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL asm_flags: empty=%b out_valid=%b want 0 0", empty, out_valid); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i < 16; i++) feed_word(32'h1000_0000 | 32'(i));
      total++; if (full !== 1'b1 || level !== 5'd16) begin
         bad++; $display("FAIL ovf_full: full=%b level=%0d want 1 16", full, level); end
      total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL ovf_nodrop: got %0d want 0", drop_cnt); end
      feed_word(32'hDEAD_BEEF);
      total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
      total++; if (full !== 1'b1 || level !== 5'd16) begin
         bad++; $display("FAIL ovf_level: full=%b level=%0d want 1 16", full, level); end
      total++; if (data_out !== 32'hA5A5_0F0F) begin bad++; $display("FAIL ovf_head: got %h want a5a50f0f", data_out); end
   endtask

   task automatic test_burst();
      got_q.delete();
      exp_q = '{32'hA5A5_0F0F, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
                32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007};
      out_ready = 1'b1;
      button = 1'b1;
      step(2);
      total++; if (loading_out !== 1'b0) begin bad++; $display("FAIL burst_early: got %b want 0", loading_out); end
      step(1);
      total++; if (loading_out !== 1'b1) begin bad++; $display("FAIL burst_latency: got %b want 1", loading_out); end
      button = 1'b0;
      wait_idle(40);
      total++; if (loading_out !== 1'b0) begin bad++; $display("FAIL burst_timeout: loading_out=%b want 0", loading_out); end
      total++; if (got_q.size() != 8) begin bad++; $display("FAIL burst_count: got %0d want 8", got_q.size()); end
      else for (int i = 0; i < 8; i++) begin
         total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL burst_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      total++; if (level !== 5'd8) begin bad++; $display("FAIL burst_level: got %0d want 8", level); end
   endtask

   task automatic test_back_to_back();
      got_q.delete();
      exp_q.delete();
      for (int i = 8; i < 16; i++) exp_q.push_back(32'h1000_0000 | 32'(i));
      button = 1'b1;
      step(3);
      button = 1'b0;
      wait_idle(40);
      total++; if (got_q.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
      else for (int i = 0; i < 8; i++) begin
         total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      total++; if (empty !== 1'b1 || level !== 5'd0 || loading_out !== 1'b0) begin
         bad++; $display("FAIL b2b_final: empty=%b level=%0d loading=%b want 1 0 0", empty, level, loading_out); end
   endtask

   task automatic test_stall();
      do_reset();
      for (int i = 1; i <= 8; i++) exp_q.push_back(32'h2000_0000 | 32'(i));
      for (int i = 1; i <= 3; i++) feed_word(exp_q[i-1]);
      out_ready = 1'b1;
      button = 1'b1;
      step(3);
      button = 1'b0;
      step(10);
      total++; if (got_q.size() != 3) begin bad++; $display("FAIL stall_count: got %0d want 3", got_q.size()); end
      total++; if (loading_out !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL stall_state: loading=%b out_valid=%b want 1 0", loading_out, out_valid); end
      for (int i = 4; i <= 8; i++) feed_word(exp_q[i-1]);
      wait_idle(10);
      total++; if (got_q.size() != 8) begin bad++; $display("FAIL stall_total: got %0d want 8", got_q.size()); end
      else for (int i = 0; i < 8; i++) begin
         total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      total++; if (loading_out !== 1'b0 || level !== 5'd0) begin
         bad++; $display("FAIL stall_end: loading=%b level=%0d want 0 0", loading_out, level); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      feed_word(32'h3000_0001);
      out_ready = 1'b0;
      button = 1'b1;
      step(3);
      button = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rnd_bit = 1'b1; rnd_valid = 1'b1;
         step(1);
      end
      rnd_valid = 1'b0; rnd_bit = 1'b0;
      total++; if (loading_out !== 1'b1 || out_valid !== 1'b1) begin
         bad++; $display("FAIL midrst_pre: loading=%b out_valid=%b want 1 1", loading_out, out_valid); end
      rst = 1'b0;
      #1;
      total++; if (loading_out !== 1'b0 || out_valid !== 1'b0 || empty !== 1'b1 || level !== 5'd0) begin
         bad++; $display("FAIL midrst_async: loading=%b valid=%b empty=%b level=%0d want 0 0 1 0",
                         loading_out, out_valid, empty, level); end
      step(1);
      rst = 1'b1;
      step(1);
      feed_word(32'h0000_00F0);
      total++; if (level !== 5'd1 || data_out !== 32'h0000_00F0) begin
         bad++; $display("FAIL midrst_partial: level=%0d data=%h want 1 000000f0", level, data_out); end
   endtask

   task automatic test_backpressure();
      logic        hold;
      logic [31:0] held;
      int          cyc;
      do_reset();
      for (int i = 0; i < 10; i++) feed_word(32'h4000_0000 | 32'(i));
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h4000_0000 | 32'(i));
      out_ready = 1'b0;
      button = 1'b1;
      step(3);
      button = 1'b0;
      total++; if (loading_out !== 1'b1) begin bad++; $display("FAIL bp_start: got %b want 1", loading_out); end
      cyc = 0;
      while (loading_out && cyc < 60) begin
         out_ready = (cyc % 3 != 0);
         if (cyc == 4) button = 1'b1;
         hold = out_valid && !out_ready;
         held = data_out;
         step(1);
         if (hold) begin
            total++; if (out_valid !== 1'b1 || data_out !== held) begin
               bad++; $display("FAIL bp_hold: valid=%b data=%h want 1 %h", out_valid, data_out, held); end
         end
         cyc++;
      end
      total++; if (loading_out !== 1'b0) begin bad++; $display("FAIL bp_timeout: loading_out=%b want 0", loading_out); end
      total++; if (got_q.size() != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", got_q.size()); end
      else for (int i = 0; i < 8; i++) begin
         total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      button = 1'b0;
      step(6);
      total++; if (loading_out !== 1'b0 || level !== 5'd2) begin
         bad++; $display("FAIL bp_ignored: loading=%b level=%0d want 0 2", loading_out, level); end
   endtask

   task automatic test_health();
      do_reset();
`ifdef TRNG_HEALTH_EN
      feed_word(32'hA5A5_0F0F);
      feed_word(32'hFFFF_FFFF);
      total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL health_set: got %b want 1", health_fail); end
      total++; if (level !== 5'd1) begin bad++; $display("FAIL health_level: got %0d want 1", level); end
      rst = 1'b0;
      #1;
      total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL health_clear: got %b want 0", health_fail); end
      step(1);
      rst = 1'b1;
      step(1);
`else
      feed_word(32'hFFFF_FFFF);
      total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL health_off: got %b want 0", health_fail); end
      total++; if (level !== 5'd1 || data_out !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL health_off_push: level=%0d data=%h want 1 ffffffff", level, data_out); end
`endif
   endtask

   initial begin
      test_reset();
      test_assembly();
      test_overflow();
      test_burst();
      test_back_to_back();
      test_stall();
      test_reset_mid_burst();
      test_backpressure();
      test_health();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
